// File: rtl/gemm_ctrl.sv
// gemm_ctrl -- sequencing controller for a single-PE GEMM engine (C = A * B).
//
// For every output element C[m][n], issues K operand reads (A[m][k], B[k][n]),
// waits for the PE accumulator to settle, then presents the result address to
// the result sink until it accepts.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                start a job (sampled in IDLE only)
//   m/k/n_size_i           job dimensions, latched on accepted start
//   busy_o, done_o         job status, one-cycle completion pulse
//   a/b_req_o, a/b_addr_o  operand read strobes and addresses (1-cycle read latency)
//   pe_valid_o, pe_clr_o   PE operand-valid and accumulator-clear
//   c_valid_o, c_ready_i,
//   c_addr_o               result handshake and write address
//   perf_cycles_o          busy-cycle counter
//
// Build option: GEMM_CTRL_PERF_EN enables the saturating busy-cycle counter;
// without it perf_cycles_o is tied to 0.
//
// state   | meaning
// IDLE    | waiting for start_i
// COMPUTE | one A/B read per cycle, k = 0..K-1
// WAIT    | last read data reaching the PE
// WRITE   | result valid, waiting for c_ready_i
// DONE    | one-cycle done_o pulse
module gemm_ctrl #(
   parameter int AddrWidth = 16,
   parameter int SizeWidth = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [SizeWidth-1:0] m_size_i,
   input  logic [SizeWidth-1:0] k_size_i,
   input  logic [SizeWidth-1:0] n_size_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 a_req_o,
   output logic                 b_req_o,
   output logic [AddrWidth-1:0] a_addr_o,
   output logic [AddrWidth-1:0] b_addr_o,
   output logic                 pe_valid_o,
   output logic                 pe_clr_o,
   output logic                 c_valid_o,
   input  logic                 c_ready_i,
   output logic [AddrWidth-1:0] c_addr_o,
   output logic [31:0]          perf_cycles_o
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COMPUTE = 3'd1,
      WAIT    = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4
   } state_e;

   state_e state_q, state_d;

   logic [SizeWidth-1:0] m_sz_q, k_sz_q, n_sz_q;
   logic [SizeWidth-1:0] m_q, n_q, k_q;
   // Running address bases so no multipliers are needed:
   //   a_row_q = m*K, b_row_q = k*N, c_addr_q = m*N+n
   logic [AddrWidth-1:0] a_row_q, b_row_q, c_addr_q;
   logic                 pe_valid_q, pe_clr_q;

   logic sizes_ok, k_last, n_last, m_last, xfer;
   logic busy, done, a_req, c_valid;

   assign sizes_ok = (m_size_i != '0) && (k_size_i != '0) && (n_size_i != '0);
   assign k_last   = (k_q == k_sz_q - SizeWidth'(1));
   assign n_last   = (n_q == n_sz_q - SizeWidth'(1));
   assign m_last   = (m_q == m_sz_q - SizeWidth'(1));
   assign xfer     = (state_q == WRITE) && c_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b1;
      done    = 1'b0;
      a_req   = 1'b0;
      c_valid = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start_i) begin
               state_d = sizes_ok ? COMPUTE : DONE;
            end
         end
         COMPUTE: begin
            a_req = 1'b1;
            if (k_last) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            state_d = WRITE;
         end
         WRITE: begin
            c_valid = 1'b1;
            if (c_ready_i) begin
               state_d = (m_last && n_last) ? DONE : COMPUTE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_sz_q   <= '0;
         k_sz_q   <= '0;
         n_sz_q   <= '0;
         m_q      <= '0;
         n_q      <= '0;
         k_q      <= '0;
         a_row_q  <= '0;
         b_row_q  <= '0;
         c_addr_q <= '0;
      end else begin
         if (state_q == IDLE && start_i && sizes_ok) begin
            m_sz_q   <= m_size_i;
            k_sz_q   <= k_size_i;
            n_sz_q   <= n_size_i;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            a_row_q  <= '0;
            b_row_q  <= '0;
            c_addr_q <= '0;
         end
         if (state_q == COMPUTE) begin
            if (k_last) begin
               k_q     <= '0;
               b_row_q <= '0;
            end else begin
               k_q     <= k_q + SizeWidth'(1);
               b_row_q <= b_row_q + AddrWidth'(n_sz_q);
            end
         end
         if (xfer) begin
            c_addr_q <= c_addr_q + AddrWidth'(1);
            if (n_last) begin
               n_q <= '0;
               if (!m_last) begin
                  m_q     <= m_q + SizeWidth'(1);
                  a_row_q <= a_row_q + AddrWidth'(k_sz_q);
               end
            end else begin
               n_q <= n_q + SizeWidth'(1);
            end
         end
      end
   end

   // Read data returns one cycle after the request, so the PE strobes are
   // the request strobes delayed by one register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pe_valid_q <= 1'b0;
         pe_clr_q   <= 1'b0;
      end else begin
         pe_valid_q <= a_req;
         pe_clr_q   <= a_req && (k_q == '0);
      end
   end

   assign busy_o     = busy;
   assign done_o     = done;
   assign a_req_o    = a_req;
   assign b_req_o    = a_req;
   assign a_addr_o   = a_req ? (a_row_q + AddrWidth'(k_q)) : '0;
   assign b_addr_o   = a_req ? (b_row_q + AddrWidth'(n_q)) : '0;
   assign pe_valid_o = pe_valid_q;
   assign pe_clr_o   = pe_clr_q;
   assign c_valid_o  = c_valid;
   assign c_addr_o   = c_valid ? c_addr_q : '0;

`ifdef GEMM_CTRL_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_q <= '0;
      end else if (state_q == IDLE && start_i) begin
         perf_q <= '0;
      end else if (busy && perf_q != '1) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_cycles_o = perf_q;
`else
   assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_gemm_ctrl.sv
// tb_gemm_ctrl -- scoreboard bench for gemm_ctrl: expected operand reads and
// result addresses are queued when a job is started and popped as the DUT
// issues them.
module tb_gemm_ctrl;

   localparam int AW = 16;
   localparam int SW = 8;

   logic          clk, rst_ni, start, busy, done;
   logic [SW-1:0] m_size, k_size, n_size;
   logic          a_req, b_req, pe_valid, pe_clr, c_valid, c_ready;
   logic [AW-1:0] a_addr, b_addr, c_addr;
   logic [31:0]   perf_cycles;

   gemm_ctrl #(.AddrWidth(AW), .SizeWidth(SW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .start_i      (start),
      .m_size_i     (m_size),
      .k_size_i     (k_size),
      .n_size_i     (n_size),
      .busy_o       (busy),
      .done_o       (done),
      .a_req_o      (a_req),
      .b_req_o      (b_req),
      .a_addr_o     (a_addr),
      .b_addr_o     (b_addr),
      .pe_valid_o   (pe_valid),
      .pe_clr_o     (pe_clr),
      .c_valid_o    (c_valid),
      .c_ready_i    (c_ready),
      .c_addr_o     (c_addr),
      .perf_cycles_o(perf_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int a;
      int b;
      bit first;
   } req_t;

   req_t req_q[$];
   int   c_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   done_cnt = 0;
   int   req_cnt = 0;
   bit   prev_req = 0;
   bit   prev_first = 0;
   bit   first_now;
   req_t r_mon;
   int   c_mon;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int mm, input int kk, input int nn);
      for (int im = 0; im < mm; im++) begin
         for (int in = 0; in < nn; in++) begin
            for (int ik = 0; ik < kk; ik++) begin
               req_q.push_back('{a: (im * kk + ik) % 65536, b: (ik * nn + in) % 65536,
                                 first: (ik == 0)});
            end
            c_q.push_back((im * nn + in) % 65536);
         end
      end
   endtask

   task automatic drive_start(input int mm, input int kk, input int nn);
      m_size = SW'(mm);
      k_size = SW'(kk);
      n_size = SW'(nn);
      start  = 1'b1;
      step();
      start  = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_a_req"}, a_req, 0);
      check_eq({tag, "_b_req"}, b_req, 0);
      check_eq({tag, "_a_addr"}, a_addr, 0);
      check_eq({tag, "_b_addr"}, b_addr, 0);
      check_eq({tag, "_pe_valid"}, pe_valid, 0);
      check_eq({tag, "_pe_clr"}, pe_clr, 0);
      check_eq({tag, "_c_valid"}, c_valid, 0);
      check_eq({tag, "_c_addr"}, c_addr, 0);
      check_eq({tag, "_perf"}, perf_cycles, 0);
   endtask

   // Scoreboard monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_ni) begin
         prev_req   = 1'b0;
         prev_first = 1'b0;
      end else begin
         check_eq("pe_valid", pe_valid, prev_req);
         check_eq("pe_clr", pe_clr, prev_first);
         first_now = 1'b0;
         if (a_req || b_req) begin
            req_cnt++;
            check_eq("b_req_eq_a_req", b_req, a_req);
            if (req_q.size() == 0) begin
               check_eq("spurious_req", 1, 0);
            end else begin
               r_mon = req_q.pop_front();
               check_eq("a_addr", a_addr, r_mon.a);
               check_eq("b_addr", b_addr, r_mon.b);
               first_now = r_mon.first;
            end
         end
         prev_req   = a_req;
         prev_first = a_req && first_now;
         if (c_valid && c_ready) begin
            if (c_q.size() == 0) begin
               check_eq("spurious_c_valid", 1, 0);
            end else begin
               c_mon = c_q.pop_front();
               check_eq("c_addr", c_addr, c_mon);
            end
         end
         if (done) done_cnt++;
      end
   end

   task automatic run_job(input int mm, input int kk, input int nn, input bit stall);
      int  d0, rc0, cyc;
      bit  held;
      logic [AW-1:0] cap;
      d0   = done_cnt;
      rc0  = req_cnt;
      held = 1'b0;
      push_exp(mm, kk, nn);
      c_ready = !stall;
      drive_start(mm, kk, nn);
      cyc = 0;
      while (done_cnt == d0 && cyc < 2000) begin
         if (stall && !held && c_valid) begin
            cap = c_addr;
            check_eq("stall_first_c_addr", cap, 0);
            for (int i = 0; i < 5; i++) begin
               check_eq("stall_c_valid", c_valid, 1);
               check_eq("stall_c_addr", c_addr, cap);
               check_eq("stall_no_req", a_req, 0);
               step();
            end
            c_ready = 1'b1;
            held    = 1'b1;
         end
         step();
         cyc++;
      end
      if (cyc >= 2000) check_eq("job_timeout", 1, 0);
      check_eq("done_pulses", done_cnt - d0, 1);
      check_eq("req_count", req_cnt - rc0, mm * kk * nn);
      check_eq("req_q_empty", req_q.size(), 0);
      check_eq("c_q_empty", c_q.size(), 0);
      step();
      check_eq("idle_after_job", busy, 0);
      check_eq("done_one_cycle", done, 0);
      c_ready = 1'b1;
   endtask

   initial begin
      int d0;
      rst_ni  = 1'b0;
      start   = 1'b0;
      m_size  = '0;
      k_size  = '0;
      n_size  = '0;
      c_ready = 1'b1;
      #12;
      check_all_zero("reset");
      step();
      rst_ni = 1'b1;
      step();
      step();

      // 1x1x1, cycle-exact
      push_exp(1, 1, 1);
      drive_start(1, 1, 1);
      check_eq("t1_req", a_req, 1);
      check_eq("t1_a_addr", a_addr, 0);
      check_eq("t1_b_addr", b_addr, 0);
      check_eq("t1_busy", busy, 1);
      step();
      check_eq("t1_pe_valid", pe_valid, 1);
      check_eq("t1_pe_clr", pe_clr, 1);
      check_eq("t1_no_req", a_req, 0);
      check_eq("t1_no_c_valid", c_valid, 0);
      step();
      check_eq("t1_c_valid", c_valid, 1);
      check_eq("t1_c_addr", c_addr, 0);
      step();
      check_eq("t1_done", done, 1);
      check_eq("t1_c_valid_off", c_valid, 0);
      step();
      check_eq("t1_done_off", done, 0);
      check_eq("t1_idle", busy, 0);
      check_eq("t1_q_empty", req_q.size() + c_q.size(), 0);

      run_job(2, 3, 2, 1'b0);
`ifndef GEMM_CTRL_PERF_EN
      check_eq("perf_tied_zero", perf_cycles, 0);
`endif
      run_job(2, 2, 3, 1'b1);
      run_job(3, 1, 2, 1'b0);

      // zero dimension: straight to DONE, no traffic
      d0 = done_cnt;
      drive_start(2, 0, 2);
      check_eq("zero_done", done, 1);
      check_eq("zero_no_req", a_req, 0);
      check_eq("zero_no_c_valid", c_valid, 0);
      step();
      check_eq("zero_done_off", done, 0);
      check_eq("zero_idle", busy, 0);
      check_eq("zero_done_pulses", done_cnt - d0, 1);

      // start while busy ignored, then reset mid-COMPUTE
      push_exp(2, 2, 2);
      drive_start(2, 2, 2);
      step();
      m_size = SW'(1);
      k_size = SW'(1);
      n_size = SW'(1);
      start  = 1'b1;
      step();
      start  = 1'b0;
      step();
      step();
      check_eq("busy_start_ignored_req", a_req, 1);
      check_eq("busy_start_ignored_addr", b_addr, 1);
      d0 = done_cnt;
      @(posedge clk);
      #2;
      rst_ni = 1'b0;
      #1;
      check_all_zero("midjob_reset");
      req_q.delete();
      c_q.delete();
      step();
      step();
      rst_ni = 1'b1;
      step();
      step();
      step();
      check_eq("reset_no_done", done_cnt - d0, 0);
      check_eq("reset_idle", busy, 0);
      run_job(1, 1, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
